// File: rtl/expgob_parser.sv
// Exp-Golomb bit-serial front-end: counts the zero prefix, captures the suffix, drives the
// downstream bit-write interface, then presents the decoded value on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for the first bit of a word
// PREFIX | counting leading zeros (M)
// SUFFIX | shifting in the M suffix bits, writing index M-1 down to 0
// FILL   | clearing downstream indices M+1..W-1
// OUT    | decoded value presented until value_rdy_i
module expgob_parser #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_i,
    input  logic             bit_vld_i,
    output logic             bit_rdy_o,
    output logic             cod_o,
    output logic [CNT_W-1:0] count_o,
    output logic             prc_o,
    output logic             busy_o,
    output logic [W-1:0]     value_o,
    output logic             value_vld_o,
    input  logic             value_rdy_i,
    output logic             err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREFIX = 3'd1,
        SUFFIX = 3'd2,
        FILL   = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [W-1:0]     VAL_ONE  = W'(1);

    state_t           state;
    logic [CNT_W-1:0] m_cnt;
    logic [CNT_W-1:0] sfx_cnt;
    logic [CNT_W-1:0] fill_idx;
    logic [W-1:0]     shreg;
    logic             take;

    assign take = bit_vld_i & bit_rdy_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_cnt       <= '0;
            sfx_cnt     <= '0;
            fill_idx    <= '0;
            shreg       <= '0;
            bit_rdy_o   <= 1'b0;
            cod_o       <= 1'b0;
            count_o     <= '0;
            prc_o       <= 1'b0;
            busy_o      <= 1'b0;
            value_o     <= '0;
            value_vld_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            prc_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE, PREFIX: begin
                    bit_rdy_o <= 1'b1;
                    if (take) begin
                        busy_o <= 1'b1;
                        if (!bit_i) begin
                            if (m_cnt == LAST_IDX) begin
                                // W-th zero: the prefix can never fit, drop the word
                                err_o  <= 1'b1;
                                busy_o <= 1'b0;
                                m_cnt  <= '0;
                                state  <= IDLE;
                            end else begin
                                m_cnt <= m_cnt + ONE;
                                state <= PREFIX;
                            end
                        end else begin
                            prc_o    <= 1'b1;
                            cod_o    <= 1'b1;
                            count_o  <= m_cnt;
                            shreg    <= VAL_ONE;
                            sfx_cnt  <= m_cnt;
                            fill_idx <= m_cnt + ONE;
                            if (m_cnt != '0) begin
                                state <= SUFFIX;
                            end else begin
                                state     <= FILL;
                                bit_rdy_o <= 1'b0;
                            end
                        end
                    end
                end
                SUFFIX: begin
                    if (take) begin
                        shreg   <= {shreg[W-2:0], bit_i};
                        prc_o   <= 1'b1;
                        cod_o   <= bit_i;
                        count_o <= sfx_cnt - ONE;
                        sfx_cnt <= sfx_cnt - ONE;
                        if (sfx_cnt == ONE) begin
                            bit_rdy_o <= 1'b0;
                            state     <= (m_cnt == LAST_IDX) ? OUT : FILL;
                        end
                    end
                end
                FILL: begin
                    prc_o   <= 1'b1;
                    cod_o   <= 1'b0;
                    count_o <= fill_idx;
                    if (fill_idx == LAST_IDX) begin
                        state <= OUT;
                    end else begin
                        fill_idx <= fill_idx + ONE;
                    end
                end
                OUT: begin
                    if (!value_vld_o) begin
                        value_vld_o <= 1'b1;
                        value_o     <= shreg - VAL_ONE;
                        busy_o      <= 1'b0;
                    end else if (value_rdy_i) begin
                        value_vld_o <= 1'b0;
                        m_cnt       <= '0;
                        bit_rdy_o   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_rdy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expgob_parser.sv
// Bench for expgob_parser: directed and random codewords checked against a stream-level
// Exp-Golomb model that derives expected writes, timing and values from accept cycles.
module tb_expgob_parser;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bit_i = 1'b0;
    logic             bit_vld_i = 1'b0;
    logic             bit_rdy_o;
    logic             cod_o;
    logic [CNT_W-1:0] count_o;
    logic             prc_o;
    logic             busy_o;
    logic [W-1:0]     value_o;
    logic             value_vld_o;
    logic             value_rdy_i = 1'b0;
    logic             err_o;

    int n_vec = 0;
    int n_err = 0;

    expgob_parser #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_i       (bit_i),
        .bit_vld_i   (bit_vld_i),
        .bit_rdy_o   (bit_rdy_o),
        .cod_o       (cod_o),
        .count_o     (count_o),
        .prc_o       (prc_o),
        .busy_o      (busy_o),
        .value_o     (value_o),
        .value_vld_o (value_vld_o),
        .value_rdy_i (value_rdy_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Drives one bit stream (optionally with overflow zeros before the codeword), records the
    // downstream activity, completes the result handshake and compares with the model.
    task automatic run_word(input logic [63:0] bits, input int nbits, input int gap,
                            input int bub_pct, input int rdy_wait, input string tag);
        int acc[64];
        int idx = 0, cyc = -1, hold = 0, wait_left, vld_cyc = -1;
        bit seen_vld = 0, acked = 0, done = 0;
        logic [W-1:0] val_seen = '0;
        int wr_idx[$], wr_cod[$], wr_cyc[$], er_cyc[$];
        int ex_idx[$], ex_cod[$], ex_cyc[$], ex_err[$];
        int p, m, mk, suf, last, ex_vld_cyc, b;
        logic [W-1:0] ex_val;

        wait_left  = rdy_wait;
        ex_vld_cyc = -1;
        ex_val     = '0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(negedge clk);
            if (cyc >= 0) cyc++;
            if (cyc == 1) begin
                n_vec++;
                if (busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_cycle1: got %b expected 1", tag, busy_o);
                end
            end
            if (prc_o === 1'b1) begin
                wr_idx.push_back(int'(count_o));
                wr_cod.push_back(int'(cod_o));
                wr_cyc.push_back(cyc);
                n_vec++;
                if (busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_on_write: got %b expected 1 at cycle %0d", tag, busy_o, cyc);
                end
            end
            if (err_o === 1'b1) begin
                er_cyc.push_back(cyc);
                n_vec++;
                if (busy_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_on_err: got %b expected 0", tag, busy_o);
                end
            end
            if (acked) begin
                n_vec++;
                if (value_vld_o !== 1'b0 || bit_rdy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s after_ack: got vld=%b rdy=%b expected vld=0 rdy=1",
                             tag, value_vld_o, bit_rdy_o);
                end
                value_rdy_i = 1'b0;
                bit_vld_i   = 1'b0;
                done        = 1;
            end else begin
                if (value_vld_o === 1'b1) begin
                    if (!seen_vld) begin
                        seen_vld = 1;
                        vld_cyc  = cyc;
                        val_seen = value_o;
                        n_vec++;
                        if (busy_o !== 1'b0) begin
                            n_err++;
                            $display("FAIL %s busy_at_vld: got %b expected 0", tag, busy_o);
                        end
                    end else begin
                        n_vec++;
                        if (value_o !== val_seen) begin
                            n_err++;
                            $display("FAIL %s value_hold: got %0d expected %0d", tag, value_o, val_seen);
                        end
                    end
                    n_vec++;
                    if (bit_rdy_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s rdy_in_out: got %b expected 0", tag, bit_rdy_o);
                    end
                    if (wait_left == 0) begin
                        value_rdy_i = 1'b1;
                        acked       = 1;
                    end else begin
                        value_rdy_i = 1'b0;
                        wait_left--;
                    end
                end else begin
                    value_rdy_i = 1'($urandom_range(1));
                end
                if (idx < nbits) begin
                    if (hold > 0 || int'($urandom_range(99)) < bub_pct) begin
                        bit_vld_i = 1'b0;
                        bit_i     = 1'($urandom_range(1));
                        if (hold > 0) hold--;
                    end else begin
                        bit_vld_i = 1'b1;
                        bit_i     = bits[nbits-1-idx];
                        if (bit_rdy_o === 1'b1) begin
                            if (cyc < 0) cyc = 0;
                            acc[idx] = cyc;
                            idx++;
                            hold = gap;
                        end
                    end
                end else begin
                    n_vec++;
                    if (bit_rdy_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s rdy_after_word: got %b expected 0 at cycle %0d", tag, bit_rdy_o, cyc);
                        bit_vld_i = 1'b0;
                    end else begin
                        bit_vld_i = 1'b1;
                        bit_i     = 1'($urandom_range(1));
                    end
                end
            end
        end
        bit_vld_i   = 1'b0;
        value_rdy_i = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout: got no handshake expected completion", tag);
        end

        // Reference: parse the stream as Exp-Golomb words using the recorded accept cycles
        p = 0;
        m = 0;
        while (p < nbits && idx == nbits) begin
            if (bits[nbits-1-p] == 1'b0) begin
                if (m == W - 1) begin
                    ex_err.push_back(acc[p] + 1);
                    m = 0;
                end else begin
                    m++;
                end
                p++;
            end else begin
                mk = p;
                p++;
                suf = 0;
                ex_idx.push_back(m); ex_cod.push_back(1); ex_cyc.push_back(acc[mk] + 1);
                for (int i = 0; i < m; i++) begin
                    b   = int'(bits[nbits-1-p]);
                    suf = suf * 2 + b;
                    ex_idx.push_back(m - 1 - i); ex_cod.push_back(b); ex_cyc.push_back(acc[p] + 1);
                    p++;
                end
                last = acc[p-1];
                for (int j = 0; m + 1 + j <= W - 1; j++) begin
                    ex_idx.push_back(m + 1 + j); ex_cod.push_back(0); ex_cyc.push_back(last + 2 + j);
                end
                ex_val     = W'((1 << m) + suf - 1);
                ex_vld_cyc = last + (W - 1 - m) + 2;
                p = nbits;
            end
        end

        n_vec++;
        if (er_cyc.size() != ex_err.size()) begin
            n_err++;
            $display("FAIL %s err_count: got %0d expected %0d", tag, er_cyc.size(), ex_err.size());
        end else begin
            foreach (ex_err[i]) begin
                n_vec++;
                if (er_cyc[i] != ex_err[i]) begin
                    n_err++;
                    $display("FAIL %s err_cycle: got %0d expected %0d", tag, er_cyc[i], ex_err[i]);
                end
            end
        end
        n_vec++;
        if (wr_idx.size() != ex_idx.size()) begin
            n_err++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, wr_idx.size(), ex_idx.size());
        end else begin
            foreach (ex_idx[i]) begin
                n_vec++;
                if (wr_idx[i] != ex_idx[i] || wr_cod[i] != ex_cod[i] || wr_cyc[i] != ex_cyc[i]) begin
                    n_err++;
                    $display("FAIL %s write[%0d]: got idx=%0d cod=%0d cyc=%0d expected idx=%0d cod=%0d cyc=%0d",
                             tag, i, wr_idx[i], wr_cod[i], wr_cyc[i], ex_idx[i], ex_cod[i], ex_cyc[i]);
                end
            end
        end
        n_vec++;
        if (val_seen !== ex_val) begin
            n_err++;
            $display("FAIL %s value: got %0d expected %0d", tag, val_seen, ex_val);
        end
        n_vec++;
        if (vld_cyc != ex_vld_cyc) begin
            n_err++;
            $display("FAIL %s vld_cycle: got %0d expected %0d", tag, vld_cyc, ex_vld_cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if (bit_rdy_o !== 1'b0 || cod_o !== 1'b0 || count_o !== '0 || prc_o !== 1'b0 ||
            busy_o !== 1'b0 || value_o !== '0 || value_vld_o !== 1'b0 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s outputs: got rdy=%b cod=%b cnt=%0d prc=%b busy=%b val=%0d vld=%b err=%b expected all 0",
                     tag, bit_rdy_o, cod_o, count_o, prc_o, busy_o, value_o, value_vld_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_vld_i   = 1'($urandom_range(1));
            bit_i       = 1'($urandom_range(1));
            value_rdy_i = 1'($urandom_range(1));
        end
        @(negedge clk);
        check_all_zero("reset");
        bit_vld_i   = 1'b0;
        value_rdy_i = 1'b0;
        rst_n       = 1'b1;
    endtask

    task automatic test_single_one();
        run_word(64'b1, 1, 0, 0, 0, "m0");
    endtask

    task automatic test_fill();
        run_word(64'b00111, 5, 0, 0, 1, "m2");
    endtask

    task automatic test_no_fill();
        run_word(64'b000000011111111, 15, 0, 0, 2, "m7");
    endtask

    task automatic test_overflow();
        run_word(64'b00000000010, 11, 0, 0, 0, "overflow");
    endtask

    task automatic test_bubbles();
        run_word(64'b00101, 5, 3, 0, 5, "bubbles");
    endtask

    task automatic test_reset_mid_suffix();
        logic [3:0] seq;
        int n = 0;
        seq = 4'b0011;
        for (int t = 0; t < 50 && n < 4; t++) begin
            @(negedge clk);
            bit_vld_i = 1'b1;
            bit_i     = seq[3-n];
            if (bit_rdy_o === 1'b1) n++;
        end
        @(negedge clk);
        bit_vld_i = 1'b0;
        n_vec++;
        if (n != 4 || prc_o !== 1'b1 || count_o !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL mid_suffix_setup: got n=%0d prc=%b cnt=%0d expected n=4 prc=1 cnt=1", n, prc_o, count_o);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_word(64'b011, 3, 0, 0, 1, "after_reset");
    endtask

    task automatic test_random();
        int m, suf, nb;
        logic [63:0] bits;
        for (int k = 0; k < 40; k++) begin
            m    = int'($urandom_range(W - 1));
            suf  = int'($urandom_range((1 << m) - 1));
            bits = 64'((1 << m) | suf);
            nb   = 2 * m + 1;
            if ($urandom_range(99) < 20) nb += W;
            run_word(bits, nb, int'($urandom_range(1)), int'($urandom_range(40)),
                     int'($urandom_range(4)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_one();
        test_fill();
        test_no_fill();
        test_overflow();
        test_bubbles();
        test_reset_mid_suffix();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
